// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave responder.
package spi_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} spi_slv_state_t;

   localparam logic [7:0] FILL_ONES  = 8'hFF;
   localparam logic [7:0] FILL_ZEROS = 8'h00;

   // Byte sent once the TX buffer is exhausted.
   function automatic logic [7:0] fill_byte(input logic ones);
      return ones ? FILL_ONES : FILL_ZEROS;
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// RST_VAL is the value the chain holds (and presents) out of reset.
module spi_sync #(
   parameter int   SYNC    = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC-1:0] chain;

   // Shift the raw input through SYNC flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) chain <= {SYNC{RST_VAL}};
      else     chain <= {chain[SYNC-2:0], d};
   end

   assign q = chain[SYNC-1];

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: shifts a preloaded TX buffer out on MISO (then a fill
// byte), captures MOSI bytes into an RX buffer readable by the host, and
// reports how many whole bytes arrived in the last transfer.
module spi_slave_responder
   import spi_pkg::*;
#(
   parameter int N    = 5,
   parameter int SYNC = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         spi_sclk,
   input  logic         spi_cs_n,
   input  logic         spi_mosi,
   output logic         spi_miso,
   output logic         spi_miso_oe,
   input  logic         tx_we,
   input  logic [N-1:0] tx_addr,
   input  logic [7:0]   tx_wdata,
   input  logic [N:0]   tx_len,
   input  logic         fill_ones,
   input  logic [N-1:0] rx_addr,
   output logic [7:0]   rx_rdata,
   output logic [N:0]   rx_count,
   output logic         busy,
   output logic         xfer_done,
   output logic         rx_overflow
);

   localparam int DEPTH = 2**N;

   spi_slv_state_t state_q, state_d;

   logic [7:0]   tx_buf [DEPTH];
   logic [7:0]   rx_buf [DEPTH];

   logic         sclk_s, cs_n_s, mosi_s, sync_ok;
   logic         sclk_q, cs_n_q, armed;
   logic         sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic         shift_rise, shift_fall, byte_end, rx_we;

   logic [N:0]   len_q, tx_ptr, ptr_inc;
   logic [7:0]   fill_q, next_byte, tx_sr;
   logic [6:0]   rx_sr;      // first seven bits of the byte; the eighth is mosi_s itself
   logic [2:0]   bit_cnt;

   spi_sync #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(spi_sclk), .q(sclk_s));
   spi_sync #(.SYNC(SYNC), .RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .d(spi_cs_n), .q(cs_n_s));
   spi_sync #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s));
   // Goes high once the chains hold real samples rather than their reset values.
   spi_sync #(.SYNC(SYNC), .RST_VAL(1'b0)) u_sync_ok   (.clk(clk), .rst(rst), .d(1'b1),     .q(sync_ok));

   // Edge-detect registers; armed blocks a transfer already in flight at reset
   // until cs_n has genuinely been observed high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_q <= 1'b0;
         cs_n_q <= 1'b1;
         armed  <= 1'b0;
      end else begin
         sclk_q <= sclk_s;
         cs_n_q <= cs_n_s;
         if (sync_ok && cs_n_s) armed <= 1'b1;
      end
   end

   assign sclk_rise  = sclk_s & ~sclk_q;
   assign sclk_fall  = ~sclk_s & sclk_q;
   assign cs_fall    = armed & cs_n_q & ~cs_n_s;
   assign cs_rise    = cs_n_s & ~cs_n_q;

   // Deselect takes priority over any sclk edge in the same cycle.
   assign shift_rise = (state_q == SHIFT) && !cs_rise && sclk_rise;
   assign shift_fall = (state_q == SHIFT) && !cs_rise && sclk_fall;
   assign byte_end   = shift_rise && (bit_cnt == 3'd7);
   assign rx_we      = byte_end && !rx_count[N];   // rx_count < DEPTH

   // Next TX byte at a byte boundary; tx_ptr saturates at len_q so fill repeats.
   always_comb begin
      ptr_inc   = (tx_ptr < len_q) ? tx_ptr + (N+1)'(1) : tx_ptr;
      next_byte = (ptr_inc < len_q) ? tx_buf[ptr_inc[N-1:0]] : fill_q;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cs_fall) state_d = SHIFT;
         SHIFT:   if (cs_rise) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy        = (state_q != IDLE);
   assign spi_miso_oe = busy;
   assign spi_miso    = busy & tx_sr[7];
   assign xfer_done   = (state_q == DONE);

   // Transfer datapath: setup on select, sample on sclk rise, shift on sclk fall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q       <= '0;
         fill_q      <= FILL_ZEROS;
         tx_ptr      <= '0;
         tx_sr       <= '0;
         rx_sr       <= '0;
         bit_cnt     <= '0;
         rx_count    <= '0;
         rx_overflow <= 1'b0;
      end else begin
         if (state_q == IDLE && cs_fall) begin
            len_q       <= tx_len;
            fill_q      <= fill_byte(fill_ones);
            tx_ptr      <= '0;
            bit_cnt     <= '0;
            rx_count    <= '0;
            rx_overflow <= 1'b0;
            tx_sr       <= (tx_len == '0) ? fill_byte(fill_ones) : tx_buf[0];
         end
         if (shift_rise) begin
            rx_sr   <= {rx_sr[5:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_end) begin
               if (rx_we) rx_count    <= rx_count + (N+1)'(1);
               else       rx_overflow <= 1'b1;
            end
         end
         if (shift_fall) begin
            if (bit_cnt != 3'd0) begin
               tx_sr <= {tx_sr[6:0], 1'b0};
            end else begin
               tx_ptr <= ptr_inc;
               tx_sr  <= next_byte;
            end
         end
      end
   end

   // Host write port of the TX buffer.
   always_ff @(posedge clk) begin
      if (tx_we) tx_buf[tx_addr] <= tx_wdata;
   end

   // SPI write port of the RX buffer; a partial byte never reaches here.
   always_ff @(posedge clk) begin
      if (rx_we) rx_buf[rx_count[N-1:0]] <= {rx_sr, mosi_s};
   end

   // Host read port of the RX buffer, one cycle latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rx_rdata <= '0;
      else     rx_rdata <= rx_buf[rx_addr];
   end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: table of whole-byte transfers plus hand
// sequences for partial-byte deselect and reset mid-transfer.
// The DUT is built with a 4-byte buffer so overflow is reachable.
module tb_spi_slave_responder;

   localparam int N    = 2;
   localparam int SYNC = 2;
   localparam int HALF = 8;   // sclk half period in clk cycles

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
   logic         spi_miso, spi_miso_oe;
   logic         tx_we = 1'b0;
   logic [N-1:0] tx_addr = '0;
   logic [7:0]   tx_wdata = '0;
   logic [N:0]   tx_len = '0;
   logic         fill_ones = 1'b0;
   logic [N-1:0] rx_addr = '0;
   logic [7:0]   rx_rdata;
   logic [N:0]   rx_count;
   logic         busy, xfer_done, rx_overflow;

   int n_chk = 0, n_pass = 0;
   int done_cnt = 0, busy_cyc = 0;
   logic [7:0] exp_q[$];

   spi_slave_responder #(.N(N), .SYNC(SYNC)) u_dut (
      .clk(clk), .rst(rst),
      .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .tx_we(tx_we), .tx_addr(tx_addr), .tx_wdata(tx_wdata),
      .tx_len(tx_len), .fill_ones(fill_ones),
      .rx_addr(rx_addr), .rx_rdata(rx_rdata), .rx_count(rx_count),
      .busy(busy), .xfer_done(xfer_done), .rx_overflow(rx_overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (xfer_done) done_cnt++;
      if (busy)      busy_cyc++;
   end

   typedef struct packed {
      logic [N:0]       len;
      logic             fill;
      logic [3:0]       nb;
      logic [0:3][7:0]  tx;
      logic [0:5][7:0]  mo;
      logic [0:5][7:0]  em;   // expected MISO bytes
      logic [N:0]       cnt;
      logic             ovf;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic write_tx(input logic [N-1:0] a, input logic [7:0] d);
      @(negedge clk);
      tx_we = 1'b1; tx_addr = a; tx_wdata = d;
      @(negedge clk);
      tx_we = 1'b0;
   endtask

   task automatic read_rx(input logic [N-1:0] a, output logic [7:0] d);
      @(negedge clk);
      rx_addr = a;
      @(negedge clk);
      d = rx_rdata;
   endtask

   // Master side: mosi changes while sclk is low, MISO sampled at the rising edge.
   task automatic spi_bits(input logic [7:0] mo, input int nb, output logic [7:0] mi);
      mi = '0;
      for (int b = 0; b < nb; b++) begin
         spi_mosi = mo[7-b];
         repeat (HALF) @(negedge clk);
         mi[7-b]  = spi_miso;
         spi_sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic start_xfer();
      @(negedge clk);
      spi_cs_n = 1'b0;
   endtask

   task automatic end_xfer(input string tag);
      int oe_k, done_k, d0;
      repeat (HALF) @(negedge clk);
      d0 = done_cnt;
      spi_cs_n = 1'b1;
      oe_k = 0; done_k = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (xfer_done) done_k = k;
         if (!spi_miso_oe) begin oe_k = k; break; end
      end
      chk({tag, "_oe_drop_in_time"}, 32'(oe_k >= 1 && oe_k <= SYNC + 2), 1);
      chk({tag, "_done_then_idle"}, done_k, oe_k - 1);
      chk({tag, "_busy_off"}, busy, 0);
      repeat (2) @(negedge clk);
      chk({tag, "_one_done_pulse"}, done_cnt - d0, 1);
   endtask

   initial begin
      logic [7:0] got, e, d;
      int d0, b0, nrd;

      vecs[0] = '{3'd3, 1'b0, 4'd3, {8'hA5, 8'h3C, 8'h0F, 8'h00},
                  {8'h11, 8'h22, 8'h33, 24'h0}, {8'hA5, 8'h3C, 8'h0F, 24'h0}, 3'd3, 1'b0};
      vecs[1] = '{3'd1, 1'b1, 4'd4, {8'hC3, 24'h0},
                  {8'h01, 8'h02, 8'h03, 8'h04, 16'h0}, {8'hC3, 8'hFF, 8'hFF, 8'hFF, 16'h0}, 3'd4, 1'b0};
      vecs[2] = '{3'd1, 1'b0, 4'd4, {8'hC3, 24'h0},
                  {8'h41, 8'h42, 8'h43, 8'h44, 16'h0}, {8'hC3, 8'h00, 8'h00, 8'h00, 16'h0}, 3'd4, 1'b0};
      vecs[3] = '{3'd4, 1'b1, 4'd6, {8'h81, 8'h42, 8'h24, 8'h18},
                  {8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5}, {8'h81, 8'h42, 8'h24, 8'h18, 8'hFF, 8'hFF}, 3'd4, 1'b1};
      vecs[4] = '{3'd0, 1'b0, 4'd2, {8'h77, 8'h77, 8'h77, 8'h77},
                  {8'h5A, 8'hA5, 32'h0}, {8'h00, 8'h00, 32'h0}, 3'd2, 1'b0};

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_miso", spi_miso, 0);
      chk("rst_miso_oe", spi_miso_oe, 0);
      chk("rst_rx_rdata", rx_rdata, 0);
      chk("rst_rx_count", rx_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_xfer_done", xfer_done, 0);
      chk("rst_rx_overflow", rx_overflow, 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // Whole-byte transfers from the table.
      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < 4; i++) write_tx(N'(i), vecs[v].tx[i]);
         tx_len = vecs[v].len;
         fill_ones = vecs[v].fill;
         start_xfer();
         for (int i = 0; i < int'(vecs[v].nb); i++) exp_q.push_back(vecs[v].em[i]);
         for (int i = 0; i < int'(vecs[v].nb); i++) begin
            spi_bits(vecs[v].mo[i], 8, got);
            if (exp_q.size() == 0) chk($sformatf("v%0d_sb_empty", v), 1, 0);
            else begin
               e = exp_q.pop_front();
               chk($sformatf("v%0d_miso%0d", v, i), got, e);
            end
         end
         end_xfer($sformatf("v%0d", v));
         chk($sformatf("v%0d_rx_count", v), rx_count, vecs[v].cnt);
         chk($sformatf("v%0d_rx_overflow", v), rx_overflow, vecs[v].ovf);
         nrd = (int'(vecs[v].nb) < 4) ? int'(vecs[v].nb) : 4;
         for (int i = 0; i < nrd; i++) begin
            read_rx(N'(i), d);
            chk($sformatf("v%0d_rx_buf%0d", v, i), d, vecs[v].mo[i]);
         end
      end

      // Deselect after 12 bits: only the whole byte is stored.
      write_tx(0, 8'hE1);
      write_tx(1, 8'h7E);
      tx_len = 3'd2; fill_ones = 1'b0;
      start_xfer();
      spi_bits(8'h99, 8, got);
      chk("part_miso0", got, 8'hE1);
      spi_bits(8'h60, 4, got);
      chk("part_miso1_hi", got[7:4], 4'h7);
      end_xfer("part");
      chk("part_rx_count", rx_count, 1);
      read_rx(0, d);
      chk("part_rx_buf0", d, 8'h99);
      read_rx(1, d);
      chk("part_rx_buf1_kept", d, 8'hA5);

      // Reset after 5 bits; the remaining clocks must be ignored.
      start_xfer();
      spi_bits(8'hAA, 5, got);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_rst_miso", spi_miso, 0);
      chk("mid_rst_miso_oe", spi_miso_oe, 0);
      chk("mid_rst_rx_rdata", rx_rdata, 0);
      chk("mid_rst_rx_count", rx_count, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rx_overflow", rx_overflow, 0);
      rst = 1'b0;
      d0 = done_cnt; b0 = busy_cyc;
      spi_bits(8'hFF, 8, got);
      spi_bits(8'hFF, 3, got);
      repeat (HALF) @(negedge clk);
      chk("post_rst_no_busy", busy_cyc - b0, 0);
      chk("post_rst_rx_count", rx_count, 0);
      spi_cs_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("post_rst_no_done", done_cnt - d0, 0);
      start_xfer();
      spi_bits(8'h3C, 8, got);
      chk("post_rst_miso_restart", got, 8'hE1);
      end_xfer("post_rst");
      chk("post_rst_rx_count1", rx_count, 1);
      read_rx(0, d);
      chk("post_rst_rx_buf0", d, 8'h3C);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
